// File: rtl/cnn_sched_pkg.sv
// Shared types and defaults for the CNN accelerator request scheduler.
package cnn_sched_pkg;

  localparam int unsigned IMG_W_DEF  = 5;
  localparam int unsigned PRED_W_DEF = 4;

  // Requester identifiers as reported on rsp_id
  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cnn_sched_if.sv
// Requester / response / accelerator signal bundle for cnn_sched.
// slave: scheduler side. master: requesters + accelerator side.
interface cnn_sched_if import cnn_sched_pkg::*; #(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned PRED_W = PRED_W_DEF
) ();

  logic              req0_valid;
  logic [IMG_W-1:0]  req0_img;
  logic              req0_ready;
  logic              req1_valid;
  logic [IMG_W-1:0]  req1_img;
  logic              req1_ready;
  logic              rsp_valid;
  logic              rsp_id;
  logic [PRED_W-1:0] rsp_pred;
  logic              rsp_err;
  logic              cnn_start;
  logic [IMG_W-1:0]  cnn_img_index;
  logic              cnn_done;
  logic [PRED_W-1:0] cnn_pred;
  logic              busy;

  modport slave (
    input  req0_valid, req0_img, req1_valid, req1_img, cnn_done, cnn_pred,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_pred, rsp_err,
           cnn_start, cnn_img_index, busy
  );

  modport master (
    output req0_valid, req0_img, req1_valid, req1_img, cnn_done, cnn_pred,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_pred, rsp_err,
           cnn_start, cnn_img_index, busy
  );

endinterface

// File: rtl/cnn_rr_arb.sv
// Two-way round-robin arbiter. Grant is combinational; the last-grant
// flag advances only when a granted request is taken.
module cnn_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_c_o
);

  logic last1_q, last1_d;

  // Grant: tie goes to the requester not served last
  always_comb begin
    gnt_c_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) gnt_c_o = last1_q ? 2'b01 : 2'b10;
      else                  gnt_c_o = valid_i;
    end
  end

  // Last-grant update on accept only
  always_comb begin
    last1_d = last1_q;
    if (|gnt_c_o) last1_d = gnt_c_o[1];
  end

  // Reset favours requester 0 on the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last1_q <= 1'b1;
    else          last1_q <= last1_d;
  end

endmodule

// File: rtl/cnn_sched.sv
// Arbitrates two requesters onto one CNN accelerator and returns the
// prediction as a one-cycle response pulse.
// Optional: CNN_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYC cycles.
module cnn_sched import cnn_sched_pkg::*; #(
  parameter int unsigned IMG_W       = IMG_W_DEF,
  parameter int unsigned PRED_W      = PRED_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  cnn_sched_if.slave bus
);

  if (TIMEOUT_CYC < 2) begin : g_timeout_chk
    $error("cnn_sched: TIMEOUT_CYC must be at least 2");
  end

  state_e            state_q, state_d;
  logic [IMG_W-1:0]  idx_q, idx_d;
  logic              id_q, id_d;
  logic              rsp_id_q, rsp_id_d;
  logic [PRED_W-1:0] rsp_pred_q, rsp_pred_d;
  logic              start_q, busy_q, rsp_valid_q;
  logic [1:0]        gnt_c;
  logic              idle_c, accept_c, timeout_c;

  // Ready only in IDLE and never while reset is held
  assign idle_c   = (state_q == ST_IDLE) && reset_n;
  assign accept_c = |gnt_c;

  cnn_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (idle_c),
    .valid_i ({bus.req1_valid, bus.req0_valid}),
    .gnt_c_o (gnt_c)
  );

  assign bus.req0_ready    = gnt_c[0];
  assign bus.req1_ready    = gnt_c[1];
  assign bus.cnn_start     = start_q;
  assign bus.cnn_img_index = idx_q;
  assign bus.busy          = busy_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_pred      = rsp_pred_q;

`ifdef CNN_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;

  // WAIT cycle counter, cleared on the way into WAIT
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_START)     cnt_d = '0;
    else if (state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
  end

  assign timeout_c = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Error flag: done beats a coincident timeout
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (state_q == ST_WAIT) begin
      if (bus.cnn_done)   rsp_err_d = 1'b0;
      else if (timeout_c) rsp_err_d = 1'b1;
    end
  end

  // Timeout state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign timeout_c   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Next state, request capture and response capture
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_pred_d = rsp_pred_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_START;
          idx_d   = gnt_c[1] ? bus.req1_img : bus.req0_img;
          id_d    = gnt_c[1] ? REQ_ID_1 : REQ_ID_0;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.cnn_done) begin
          state_d    = ST_RESP;
          rsp_id_d   = id_q;
          rsp_pred_d = bus.cnn_pred;
        end else if (timeout_c) begin
          state_d    = ST_RESP;
          rsp_id_d   = id_q;
          rsp_pred_d = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      id_q        <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_pred_q  <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_pred_q  <= rsp_pred_d;
      start_q     <= (state_d == ST_START);
      busy_q      <= (state_d != ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
    end
  end

endmodule

// File: tb/tb_cnn_sched.sv
// Bench for cnn_sched: directed scenarios followed by random requester
// traffic, compared against a transaction-level model of the scheduler.
module tb_cnn_sched;
  import cnn_sched_pkg::*;

  localparam int unsigned IMG_W  = 5;
  localparam int unsigned PRED_W = 4;
  localparam int unsigned TO_CYC = 16;
`ifdef CNN_TIMEOUT_EN
  localparam int MAX_DLY = 20;
`else
  localparam int MAX_DLY = 12;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cnn_sched_if #(.IMG_W(IMG_W), .PRED_W(PRED_W)) bus ();

  cnn_sched #(.IMG_W(IMG_W), .PRED_W(PRED_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: last served requester, pending requests, last response fields
  bit                last1;
  bit                pend [2];
  logic [IMG_W-1:0]  pimg [2];
  logic              hold_id;
  logic [PRED_W-1:0] hold_pred;
  logic              hold_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    if (pend[0] && pend[1]) return last1 ? 0 : 1;
    if (pend[0]) return 0;
    if (pend[1]) return 1;
    return -1;
  endfunction

  task automatic drive_reqs();
    bus.req0_valid = pend[0];
    bus.req0_img   = pimg[0];
    bus.req1_valid = pend[1];
    bus.req1_img   = pimg[1];
  endtask

  task automatic check_outs(input string ph, input logic e_busy, input logic e_start,
                            input logic [IMG_W-1:0] e_idx, input logic e_rv,
                            input logic e_r0, input logic e_r1);
    check({ph, ".busy"},   32'(bus.busy),          32'(e_busy));
    check({ph, ".start"},  32'(bus.cnn_start),     32'(e_start));
    check({ph, ".idx"},    32'(bus.cnn_img_index), 32'(e_idx));
    check({ph, ".rv"},     32'(bus.rsp_valid),     32'(e_rv));
    check({ph, ".ready0"}, 32'(bus.req0_ready),    32'(e_r0));
    check({ph, ".ready1"}, 32'(bus.req1_ready),    32'(e_r1));
    check({ph, ".rsp_id"}, 32'(bus.rsp_id),        32'(hold_id));
    check({ph, ".pred"},   32'(bus.rsp_pred),      32'(hold_pred));
    check({ph, ".err"},    32'(bus.rsp_err),       32'(hold_err));
  endtask

  // Asynchronous reset from the current point; requesters stay as they are
  // for the first check so ready gating under reset is exercised.
  task automatic apply_reset();
    reset_n   = 1'b0;
    hold_id   = 1'b0;
    hold_pred = '0;
    hold_err  = 1'b0;
    #1;
    check_outs("rst", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last1   = 1'b1;
    drive_reqs();
    bus.cnn_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One IDLE cycle with no requests, optionally with a stray cnn_done
  task automatic idle_cycle(input bit spur);
    drive_reqs();
    bus.cnn_done = spur;
    bus.cnn_pred = PRED_W'($urandom);
    @(negedge clk);
    bus.cnn_done = 1'b0;
    #1;
    check_outs("idle", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // One transaction from an IDLE cycle; delay = cycles from cnn_start to cnn_done
  task automatic run_txn(input int delay, input logic [PRED_W-1:0] pred,
                         input bit spur_start, input bit spur_resp, input bit abort);
    int w;
    int n;
    bit fires;
    logic [IMG_W-1:0] img;
    drive_reqs();
    #1;
    w = model_grant();
    check_outs("acc", 1'b0, 1'b0, '0, 1'b0, w == 0, w == 1);
    img     = pimg[w];
    last1   = (w == 1);
    pend[w] = 1'b0;
`ifdef CNN_TIMEOUT_EN
    fires = (delay > int'(TO_CYC));
    n     = fires ? int'(TO_CYC) : delay;
`else
    fires = 1'b0;
    n     = delay;
`endif
    @(negedge clk);
    drive_reqs();
    #1;
    check_outs("start", 1'b1, 1'b1, img, 1'b0, 1'b0, 1'b0);
    if (spur_start) begin
      bus.cnn_done = 1'b1;
      bus.cnn_pred = PRED_W'($urandom);
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.cnn_done = 1'b0;
      #1;
      check_outs("wait", 1'b1, 1'b0, img, 1'b0, 1'b0, 1'b0);
      if (abort && k == 1) begin
        apply_reset();
        return;
      end
      if (!fires && k == delay) begin
        bus.cnn_done = 1'b1;
        bus.cnn_pred = pred;
      end
    end
    @(negedge clk);
    bus.cnn_done = spur_resp;
    bus.cnn_pred = PRED_W'($urandom);
    #1;
    hold_id   = (w == 1);
    hold_pred = fires ? '0 : pred;
    hold_err  = fires;
    check_outs("resp", 1'b1, 1'b0, img, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.cnn_done = 1'b0;
    #1;
    w = model_grant();
    check_outs("post", 1'b0, 1'b0, '0, 1'b0, w == 0, w == 1);
  endtask

  task automatic raise(input int r);
    if (!pend[r]) begin
      pend[r] = 1'b1;
      pimg[r] = IMG_W'($urandom);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    pend[0]        = 1'b0;
    pend[1]        = 1'b0;
    pimg[0]        = '0;
    pimg[1]        = '0;
    bus.cnn_done   = 1'b0;
    bus.cnn_pred   = '0;
    drive_reqs();
    @(negedge clk);
    apply_reset();

    // req0 image 7, done 10 cycles after start with prediction 3
    pend[0] = 1'b1;
    pimg[0] = 5'd7;
    run_txn(10, 4'd3, 1'b0, 1'b0, 1'b0);
    check("dir31.id", 32'(bus.rsp_id), 32'd0);
    check("dir31.pred", 32'(bus.rsp_pred), 32'd3);

    // Stray done in IDLE, START and RESP
    idle_cycle(1'b1);
    raise(0);
    run_txn(4, PRED_W'($urandom), 1'b1, 1'b1, 1'b0);

    // Round robin from reset with both requesters always asking
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      raise(0);
      raise(1);
      run_txn(int'($urandom_range(1, 6)), PRED_W'($urandom), 1'b0, 1'b0, 1'b0);
      check("rr.order", 32'(bus.rsp_id), 32'(i % 2));
    end

`ifdef CNN_TIMEOUT_EN
    // No done: abort after TIMEOUT_CYC wait cycles; done on last cycle wins
    raise(0);
    run_txn(int'(TO_CYC) + 5, 4'd9, 1'b0, 1'b0, 1'b0);
    raise(1);
    run_txn(int'(TO_CYC), 4'd9, 1'b0, 1'b0, 1'b0);
`endif

    // Reset during WAIT, then a stray done, then a clean transaction
    raise(0);
    raise(1);
    run_txn(8, PRED_W'($urandom), 1'b0, 1'b0, 1'b1);
    idle_cycle(1'b1);
    raise(1);
    run_txn(3, 4'd5, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++)
        if ($urandom_range(0, 9) < 6) raise(r);
      if (!pend[0] && !pend[1]) begin
        idle_cycle(bit'($urandom_range(0, 1)));
      end else begin
        run_txn(int'($urandom_range(1, MAX_DLY)), PRED_W'($urandom),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_sched.md
CNN_SCHED -- requirements
Module: cnn_sched

Interface
REQ-001 Parameter IMG_W, default 5, image-index width.
REQ-002 Parameter PRED_W, default 4, prediction width.
REQ-003 Parameter TIMEOUT_CYC, default 4096, max WAIT cycles before abort (used only with CNN_TIMEOUT_EN).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port req0_valid / req0_img / req0_ready  in 1 / in IMG_W / out 1  requester 0 (core EX-stage CNN op).
REQ-007 Port req1_valid / req1_img / req1_ready  in 1 / in IMG_W / out 1  requester 1 (host/debug port).
REQ-008 Port rsp_valid / rsp_id / rsp_pred / rsp_err  out 1 / out 1 / out PRED_W / out 1  one-cycle result pulse, requester id, prediction, timeout flag.
REQ-009 Port cnn_start / cnn_img_index  out 1 / out IMG_W  accelerator launch pulse and image index.
REQ-010 Port cnn_done / cnn_pred  in 1 / in PRED_W  accelerator completion pulse and prediction.
REQ-011 Port busy  output 1  high in any state other than IDLE; used as core stall.

Function
REQ-012 FSM states IDLE, START, WAIT, RESP; encoding free.
REQ-013 IDLE: reqN_ready asserted combinationally only for the granted requester; accept on valid&&ready.
REQ-014 Arbitration round-robin: both valid -> grant the one not granted last; single valid -> grant it; last-grant flag updates only on accept.
REQ-015 Accept: latch img and id; IDLE->START.
REQ-016 START: cnn_start=1 exactly one cycle; ->WAIT.
REQ-017 cnn_img_index holds latched img from START through RESP; 0 in IDLE.
REQ-018 WAIT: cnn_done=1 -> capture cnn_pred, err=0, ->RESP.
REQ-019 RESP: rsp_valid=1 one cycle with rsp_id, rsp_pred, rsp_err; ->IDLE; no accept in this cycle.
REQ-020 Latency: accept at cycle T -> cnn_start at T+1; cnn_done at D -> rsp_valid at D+1.
REQ-021 cnn_done in IDLE, START or RESP ignored; no state change, no capture.
REQ-022 cnn_done and timeout in the same cycle: done wins, err=0.
REQ-023 rsp_pred/rsp_id/rsp_err hold last values when rsp_valid=0.
REQ-024 Both reqN_ready=0 whenever busy=1; no back-to-back accept faster than every 4 cycles.

Reset
REQ-025 reset_n low: state IDLE, all outputs 0, last-grant flag selects requester 1 (so requester 0 wins first tie), timeout counter 0.
REQ-026 Reset mid-operation aborts transaction silently; no rsp_valid; in-flight cnn_done after release ignored per REQ-021.

Configuration
REQ-027 Macro CNN_TIMEOUT_EN defined: WAIT counter increments each WAIT cycle, cleared on entering WAIT; reaching TIMEOUT_CYC-1 without done -> RESP with rsp_pred=0, rsp_err=1.
REQ-028 CNN_TIMEOUT_EN undefined: no counter, WAIT exits only on cnn_done, rsp_err tied 0.

Structure
REQ-029 Shared package holds FSM state typedef, default IMG_W/PRED_W, requester-id constants.
REQ-030 One sub-module natural: cnn_rr_arb (2-way round-robin grant with last-grant flag); rest in cnn_sched.

Verification
REQ-031 req0 img=7, cnn_done 10 cycles after cnn_start with pred=3 -> cnn_start 1 cycle after accept, cnn_img_index=7, rsp_valid next cycle after done, rsp_id=0, rsp_pred=3, rsp_err=0.
REQ-032 req0 and req1 valid together, repeated 4 transactions -> grants 0,1,0,1 from reset.
REQ-033 Spurious cnn_done in IDLE and START -> no state change, no rsp_valid.
REQ-034 CNN_TIMEOUT_EN, TIMEOUT_CYC=16, no done -> rsp_valid after 16 WAIT cycles, rsp_err=1, rsp_pred=0; done on final cycle -> err=0.
REQ-035 reset_n low during WAIT -> all outputs 0 immediately, no rsp_valid; next request completes normally.
REQ-036 New req1 valid during busy -> req1_ready=0 until IDLE, accepted cycle after RESP.
